// File: rtl/uart_pkg.sv
// Shared types and constants for the RAM1-bus soft UART.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   // COM1 addresses decoded by the memory controller
   localparam logic [31:0] COM1_DATA_ADDR = 32'hBFD0_03F8;
   localparam logic [31:0] COM1_CMD_ADDR  = 32'hBFD0_03FC;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// rxd synchroniser, mid-bit sampler and 8N1 receive FSM.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 96,
   parameter int RX_SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rxd,
   output logic [UART_DATA_BITS-1:0] rx_byte,
   output logic                      rx_valid,
   output logic                      framing_err
);
   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]        BIT_LAST = 3'(UART_DATA_BITS - 1);

   logic [RX_SYNC_STAGES-1:0] sync_r;
   logic                      rx_s;
   logic                      rx_prev_r;
   rx_state_t                 state_r, state_s;
   logic [CNT_W-1:0]          cnt_r, cnt_s;
   logic [2:0]                idx_r, idx_s;
   logic [7:0]                shift_r, shift_s;
   logic [7:0]                byte_r, byte_s;
   logic                      valid_r, valid_s;
   logic                      ferr_r, ferr_s;

   assign rx_s        = sync_r[RX_SYNC_STAGES-1];
   assign rx_byte     = byte_r;
   assign rx_valid    = valid_r;
   assign framing_err = ferr_r;

   // Metastability synchroniser for the asynchronous serial input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_r <= {RX_SYNC_STAGES{1'b1}};
      else      sync_r <= RX_SYNC_STAGES'({sync_r, rxd});
   end

   // RX state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= RX_IDLE;
      else      state_r <= state_s;
   end

   // RX next-state: falling edge arms, mid-start glitch aborts, stop ends the frame
   always_comb begin
      state_s = state_r;
      case (state_r)
         RX_IDLE:  if (rx_prev_r && !rx_s) state_s = RX_START; else state_s = RX_IDLE;
         RX_START: if (cnt_r == CNT_HALF) state_s = rx_s ? RX_IDLE : RX_DATA;
                   else state_s = RX_START;
         RX_DATA:  if ((cnt_r == CNT_LAST) && (idx_r == BIT_LAST)) state_s = RX_STOP;
                   else state_s = RX_DATA;
         RX_STOP:  if (cnt_r == CNT_LAST) state_s = RX_IDLE; else state_s = RX_STOP;
         default:  state_s = RX_IDLE;
      endcase
   end

   // RX datapath: counter restarts at mid-start so later samples land mid-bit
   always_comb begin
      cnt_s   = cnt_r + CNT_ONE;
      idx_s   = idx_r;
      shift_s = shift_r;
      byte_s  = byte_r;
      valid_s = 1'b0;
      ferr_s  = 1'b0;
      case (state_r)
         RX_IDLE: cnt_s = CNT_ZERO;
         RX_START: begin
            if (cnt_r == CNT_HALF) begin
               cnt_s = CNT_ZERO;
               idx_s = 3'd0;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         RX_DATA: begin
            if (cnt_r == CNT_LAST) begin
               cnt_s   = CNT_ZERO;
               shift_s = {rx_s, shift_r[7:1]};
               idx_s   = idx_r + 3'd1;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         RX_STOP: begin
            if (cnt_r == CNT_LAST) begin
               cnt_s = CNT_ZERO;
               if (rx_s) begin
                  byte_s  = shift_r;
                  valid_s = 1'b1;
               end else begin
                  ferr_s = 1'b1;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: cnt_s = CNT_ZERO;
      endcase
   end

   // RX datapath registers and registered result pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_prev_r <= 1'b1;
         cnt_r     <= CNT_ZERO;
         idx_r     <= 3'd0;
         shift_r   <= 8'h00;
         byte_r    <= 8'h00;
         valid_r   <= 1'b0;
         ferr_r    <= 1'b0;
      end else begin
         rx_prev_r <= rx_s;
         cnt_r     <= cnt_s;
         idx_r     <= idx_s;
         shift_r   <= shift_s;
         byte_r    <= byte_s;
         valid_r   <= valid_s;
         ferr_r    <= ferr_s;
      end
   end

endmodule

// File: rtl/uart_bus_responder.sv
// Soft 8N1 UART answering the memory controller's rdn/wrn strobe protocol.
module uart_bus_responder
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 96,
   parameter int RX_SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire  [7:0] bus_data,
   input  logic       rdn,
   input  logic       wrn,
   output logic       data_ready,
   output logic       tbre,
   output logic       tsre,
   output logic       overrun,
   output logic       framing_err,
   output logic       txd,
   input  logic       rxd
);
   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

   logic rdn_q_r, wrn_q_r, rdn_rise_s, wrn_rise_s, thr_write_s;
   logic [7:0] wr_latch_r, thr_r, tsr_r, tsr_s, tx_src_s, rbr_r, rx_byte_s;
   logic tbre_r, tbre_s, tsre_r, tsre_s, txd_r, txd_s;
   logic data_ready_r, data_ready_s, overrun_r, overrun_s, rx_valid_s;
   logic tx_bit_end_s, tx_pending_s, tx_load_s;
   tx_state_t tx_state_r, tx_state_s;
   logic [CNT_W-1:0] tx_cnt_r, tx_cnt_s;
   logic [2:0] tx_idx_r, tx_idx_s;

   assign bus_data    = rdn ? 8'bzzzzzzzz : rbr_r;
   assign data_ready  = data_ready_r;
   assign tbre        = tbre_r;
   assign tsre        = tsre_r;
   assign overrun     = overrun_r;
   assign txd         = txd_r;

   assign rdn_rise_s   = rdn && !rdn_q_r;
   assign wrn_rise_s   = wrn && !wrn_q_r;
   assign thr_write_s  = wrn_rise_s && tbre_r;
   assign tx_bit_end_s = (tx_cnt_r == CNT_LAST);
   // A write accepted in the last STOP cycle still counts as pending
   assign tx_pending_s = !tbre_r || thr_write_s;
   assign tx_src_s     = tbre_r ? wr_latch_r : thr_r;
   assign tx_load_s    = ((tx_state_r == TX_IDLE) && !tbre_r) ||
                         ((tx_state_r == TX_STOP) && tx_bit_end_s && tx_pending_s);
   assign tbre_s       = tx_load_s ? 1'b1 : (thr_write_s ? 1'b0 : tbre_r);

   uart_rx_sampler #(
      .CLKS_PER_BIT   (CLKS_PER_BIT),
      .RX_SYNC_STAGES (RX_SYNC_STAGES)
   ) u_rx (
      .clk         (clk),
      .rst         (rst),
      .rxd         (rxd),
      .rx_byte     (rx_byte_s),
      .rx_valid    (rx_valid_s),
      .framing_err (framing_err)
   );

   // Strobe history, bus capture while wrn is low, and holding register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdn_q_r    <= 1'b1;
         wrn_q_r    <= 1'b1;
         wr_latch_r <= 8'h00;
         thr_r      <= 8'h00;
         tbre_r     <= 1'b1;
      end else begin
         rdn_q_r <= rdn;
         wrn_q_r <= wrn;
         if (!wrn) wr_latch_r <= bus_data;
         if (thr_write_s) thr_r <= wr_latch_r;
         tbre_r <= tbre_s;
      end
   end

   // TX state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tx_state_r <= TX_IDLE;
      else      tx_state_r <= tx_state_s;
   end

   // TX next-state: each state lasts one bit time, STOP chains straight into START
   always_comb begin
      tx_state_s = tx_state_r;
      case (tx_state_r)
         TX_IDLE:  if (!tbre_r) tx_state_s = TX_START; else tx_state_s = TX_IDLE;
         TX_START: if (tx_bit_end_s) tx_state_s = TX_DATA; else tx_state_s = TX_START;
         TX_DATA:  if (tx_bit_end_s && (tx_idx_r == BIT_LAST)) tx_state_s = TX_STOP;
                   else tx_state_s = TX_DATA;
         TX_STOP:  if (tx_bit_end_s) tx_state_s = tx_pending_s ? TX_START : TX_IDLE;
                   else tx_state_s = TX_STOP;
         default:  tx_state_s = TX_IDLE;
      endcase
   end

   // TX outputs: next txd, shift register and line-idle flag
   always_comb begin
      tsr_s    = tsr_r;
      txd_s    = txd_r;
      tsre_s   = tsre_r;
      tx_idx_s = tx_idx_r;
      tx_cnt_s = tx_cnt_r + CNT_ONE;
      if (tx_load_s) begin
         tsr_s    = tx_src_s;
         txd_s    = 1'b0;
         tsre_s   = 1'b0;
         tx_cnt_s = CNT_ZERO;
      end else begin
         case (tx_state_r)
            TX_IDLE: tx_cnt_s = CNT_ZERO;
            TX_START: begin
               if (tx_bit_end_s) begin
                  txd_s    = tsr_r[0];
                  tx_cnt_s = CNT_ZERO;
                  tx_idx_s = 3'd0;
               end else begin
                  tx_cnt_s = tx_cnt_r + CNT_ONE;
               end
            end
            TX_DATA: begin
               if (tx_bit_end_s) begin
                  tx_cnt_s = CNT_ZERO;
                  if (tx_idx_r == BIT_LAST) begin
                     txd_s = 1'b1;
                  end else begin
                     tsr_s    = {1'b0, tsr_r[7:1]};
                     txd_s    = tsr_r[1];
                     tx_idx_s = tx_idx_r + 3'd1;
                  end
               end else begin
                  tx_cnt_s = tx_cnt_r + CNT_ONE;
               end
            end
            TX_STOP: begin
               if (tx_bit_end_s) begin
                  tx_cnt_s = CNT_ZERO;
                  tsre_s   = 1'b1;
               end else begin
                  tx_cnt_s = tx_cnt_r + CNT_ONE;
               end
            end
            default: tx_cnt_s = CNT_ZERO;
         endcase
      end
   end

   // TX datapath registers; reset forces the line idle immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tsr_r    <= 8'h00;
         txd_r    <= 1'b1;
         tsre_r   <= 1'b1;
         tx_idx_r <= 3'd0;
         tx_cnt_r <= CNT_ZERO;
      end else begin
         tsr_r    <= tsr_s;
         txd_r    <= txd_s;
         tsre_r   <= tsre_s;
         tx_idx_r <= tx_idx_s;
         tx_cnt_r <= tx_cnt_s;
      end
   end

   // Receive flags: a byte landing with a read-end wins and is not an overrun
   always_comb begin
      if (rx_valid_s)      data_ready_s = 1'b1;
      else if (rdn_rise_s) data_ready_s = 1'b0;
      else                 data_ready_s = data_ready_r;
      if (rx_valid_s && data_ready_r && !rdn_rise_s) overrun_s = 1'b1;
      else if (rdn_rise_s)                           overrun_s = 1'b0;
      else                                           overrun_s = overrun_r;
   end

   // Receive buffer and flag registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rbr_r        <= 8'h00;
         data_ready_r <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         if (rx_valid_s) rbr_r <= rx_byte_s;
         data_ready_r <= data_ready_s;
         overrun_r    <= overrun_s;
      end
   end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder with a 4-clock bit time.
module tb_uart_bus_responder;
   localparam int CPB = 4;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit k = line level during bit slot k (0 = start)
   } tx_vec_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_ready;
      logic [7:0] exp_rbr;
      int         exp_ferr;
   } rx_vec_t;

   logic       clk = 1'b0;
   logic       rst, rdn, wrn, rxd;
   logic       drv_en;
   logic [7:0] drv_val;
   wire  [7:0] bus_data;
   logic       data_ready, tbre, tsre, overrun, framing_err, txd;
   int         errors = 0;
   int         checks = 0;
   int         ferr_total = 0;

   tx_vec_t tx_tab[4];
   rx_vec_t rx_tab[5];

   assign bus_data = drv_en ? drv_val : 8'bzzzzzzzz;

   always #5 clk = ~clk;

   always @(negedge clk) if (framing_err) ferr_total <= ferr_total + 1;

   uart_bus_responder #(.CLKS_PER_BIT(CPB), .RX_SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus_data    (bus_data),
      .rdn         (rdn),
      .wrn         (wrn),
      .data_ready  (data_ready),
      .tbre        (tbre),
      .tsre        (tsre),
      .overrun     (overrun),
      .framing_err (framing_err),
      .txd         (txd),
      .rxd         (rxd)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [7:0] d);
      @(negedge clk); wrn = 1'b0; drv_en = 1'b1; drv_val = d;
      @(negedge clk); wrn = 1'b1; drv_en = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] exp, input string name);
      @(negedge clk); rdn = 1'b0;
      @(negedge clk);
      chk({name, " bus"}, 32'(bus_data), 32'(exp));
      rdn = 1'b1;
      @(negedge clk);
      chk({name, " ready_clr"}, 32'(data_ready), 32'd0);
      chk({name, " ovr_clr"}, 32'(overrun), 32'd0);
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop, input logic chk_low);
      @(negedge clk); rxd = 1'b0;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); rxd = d[i];
         repeat (CPB - 1) @(negedge clk);
      end
      @(negedge clk); rxd = stop;
      @(negedge clk);
      if (chk_low) chk("rx ready_before_stop", 32'(data_ready), 32'd0);
      repeat (CPB - 2) @(negedge clk);
      @(negedge clk); rxd = 1'b1;
   endtask

   task automatic wait_txd_low(input string name);
      int n = 0;
      while (txd !== 1'b0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(txd), 32'd0);
   endtask

   // Entered at the first negedge of a start bit; leaves one frame later
   task automatic check_tx_frame(input logic [9:0] frame, input string name);
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("%s bit%0d", name, k), 32'(txd), 32'(frame[k]));
         if (k < 9) repeat (CPB) @(negedge clk);
      end
      repeat (CPB - 1) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int f0, lows;
      tx_tab[0] = '{8'hA5, 10'h34A};
      tx_tab[1] = '{8'h00, 10'h200};
      tx_tab[2] = '{8'hFF, 10'h3FE};
      tx_tab[3] = '{8'h5A, 10'h2B4};
      rx_tab[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 0};
      rx_tab[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
      rx_tab[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
      rx_tab[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
      rx_tab[4] = '{8'h96, 1'b0, 1'b0, 8'hFF, 1};

      rst = 1'b0; rdn = 1'b1; wrn = 1'b1; rxd = 1'b1; drv_en = 1'b0; drv_val = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("reset txd", 32'(txd), 32'd1);
      chk("reset tbre", 32'(tbre), 32'd1);
      chk("reset tsre", 32'(tsre), 32'd1);
      chk("reset data_ready", 32'(data_ready), 32'd0);
      chk("reset overrun", 32'(overrun), 32'd0);
      chk("reset framing_err", 32'(framing_err), 32'd0);
      drv_en = 1'b1; drv_val = 8'h5A;
      @(negedge clk);
      chk("bus released", 32'(bus_data), 32'h5A);
      drv_en = 1'b0;

      // Single-byte transmit vectors
      for (int v = 0; v < 4; v++) begin
         do_write(tx_tab[v].data);
         @(negedge clk);
         chk($sformatf("tx%0d tbre_busy", v), 32'(tbre), 32'd0);
         @(negedge clk);
         chk($sformatf("tx%0d tbre_free", v), 32'(tbre), 32'd1);
         chk($sformatf("tx%0d tsre_busy", v), 32'(tsre), 32'd0);
         chk($sformatf("tx%0d start", v), 32'(txd), 32'd0);
         check_tx_frame(tx_tab[v].frame, $sformatf("tx%0d", v));
         chk($sformatf("tx%0d tsre_idle", v), 32'(tsre), 32'd1);
         chk($sformatf("tx%0d line_idle", v), 32'(txd), 32'd1);
      end

      // Back-to-back frames; a write while THR is full is dropped
      fork
         begin
            do_write(8'h11);
            @(negedge clk);
            do_write(8'h22);
            do_write(8'h33);
            @(negedge clk);
            chk("b2b third_ignored tbre", 32'(tbre), 32'd0);
         end
         begin
            wait_txd_low("b2b start");
            check_tx_frame(10'h222, "b2b f1");
            check_tx_frame(10'h244, "b2b f2");
            chk("b2b tsre_idle", 32'(tsre), 32'd1);
         end
      join
      lows = 0;
      repeat (20) begin
         @(negedge clk);
         if (txd == 1'b0) lows++;
      end
      chk("b2b no_third_frame", 32'(lows), 32'd0);
      chk("b2b tbre_final", 32'(tbre), 32'd1);

      // Receive 0x3C with data_ready timing
      send_rx(8'h3C, 1'b1, 1'b1);
      begin
         int n = 0;
         while (data_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
         end
      end
      chk("rx3C ready", 32'(data_ready), 32'd1);
      do_read(8'h3C, "rx3C read");

      // Receive vectors, including a framing error
      for (int v = 0; v < 5; v++) begin
         f0 = ferr_total;
         send_rx(rx_tab[v].data, rx_tab[v].stop, 1'b0);
         repeat (10) @(negedge clk);
         chk($sformatf("rxv%0d ready", v), 32'(data_ready), 32'(rx_tab[v].exp_ready));
         chk($sformatf("rxv%0d ferr_pulses", v), 32'(ferr_total - f0), 32'(rx_tab[v].exp_ferr));
         do_read(rx_tab[v].exp_rbr, $sformatf("rxv%0d read", v));
      end

      // Overrun: two bytes without a read
      send_rx(8'h01, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      chk("ovr first_ready", 32'(data_ready), 32'd1);
      chk("ovr not_yet", 32'(overrun), 32'd0);
      send_rx(8'h02, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      chk("ovr set", 32'(overrun), 32'd1);
      do_read(8'h02, "ovr read");

      // One-cycle glitch on rxd is not a start bit
      f0 = ferr_total;
      @(negedge clk); rxd = 1'b0;
      @(negedge clk); rxd = 1'b1;
      repeat (60) @(negedge clk);
      chk("glitch ready", 32'(data_ready), 32'd0);
      chk("glitch ferr", 32'(ferr_total - f0), 32'd0);

      // Reset mid-transmit forces the line idle at once
      do_write(8'hA5);
      wait_txd_low("rst_mid start");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid txd", 32'(txd), 32'd1);
      chk("rst_mid tbre", 32'(tbre), 32'd1);
      chk("rst_mid tsre", 32'(tsre), 32'd1);
      chk("rst_mid data_ready", 32'(data_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
- Soft UART peripheral that sits on the low byte of the shared RAM1 data bus.
- Answers the memory controller's UART strobe protocol: rdn, wrn, data_ready, tbre, tsre.
- Serialises written bytes onto txd and deserialises rxd into a receive buffer.
- Replaces the external UART chip so the CPU's COM1 data/command accesses work unchanged; format is fixed 8N1.

Parameters:
- CLKS_PER_BIT, 96, clk cycles per serial bit (11.0592 MHz / 115200); must be >= 4.
- RX_SYNC_STAGES, 2, flops in the rxd metastability synchroniser.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- bus_data  inout  8  shared data bus low byte; driven only while rdn==0, else high-Z.
- rdn  in  1  read strobe, active low, synchronous to clk.
- wrn  in  1  write strobe, active low, synchronous to clk.
- data_ready  out  1  receive buffer holds an unread byte.
- tbre  out  1  transmit holding register empty.
- tsre  out  1  transmit shift register empty; line idle.
- overrun  out  1  sticky: a received byte overwrote an unread one; cleared by a read.
- framing_err  out  1  one-cycle pulse: stop bit sampled 0.
- txd  out  1  serial output, idle high.
- rxd  in  1  serial input, asynchronous.

Behaviour:
- Reset (async, rst==0): data_ready=0, tbre=1, tsre=1, overrun=0, framing_err=0, txd=1, bus released; both FSMs to IDLE; THR, TSR and RBR cleared.
- Reset mid-frame aborts immediately; txd returns to 1 in the same cycle.
- Strobe edge detect: rdn_q and wrn_q are registered copies. A rise is strobe==1 && strobe_q==0.

Write path:
- Every cycle with wrn==0, bus_data is captured into wr_latch.
- On a wrn rise with tbre==1: THR<=wr_latch and tbre<=0.
- On a wrn rise with tbre==0: the write is ignored and THR is kept.
- wrn held low for many cycles counts as one write.

TX FSM (IDLE, START, DATA, STOP):
- IDLE with tbre==0: TSR<=THR, tbre<=1, tsre<=0, txd<=0, go to START. This happens one cycle after the wrn rise.
- Each state lasts exactly CLKS_PER_BIT cycles.
- DATA shifts 8 bits LSB first.
- STOP drives txd=1.
- At the end of STOP: if tbre==0, load the next byte directly into START (back-to-back, no idle gap). Otherwise go to IDLE with tsre<=1.
- A THR write accepted during STOP's last cycle is also taken back-to-back.

Read path:
- bus_data=RBR while rdn==0.
- On an rdn rise: data_ready<=0 and overrun<=0.

RX FSM (IDLE, START, DATA, STOP), on the synchronised rxd:
- IDLE: a 1->0 transition goes to START.
- START: at CLKS_PER_BIT/2, rxd==1 is a glitch and returns to IDLE; otherwise the bit counter restarts.
- DATA: samples 8 bits at mid-bit, spaced CLKS_PER_BIT apart, LSB first.
- STOP, mid-bit sample==1: RBR<=shift and data_ready<=1. If data_ready was already 1, set overrun<=1. Then IDLE.
- STOP, mid-bit sample==0: byte discarded, framing_err pulses for 1 cycle, RBR unchanged, wait for rxd==1 before re-arming.
- A byte completing in the same cycle as an rdn rise wins: data_ready stays 1, RBR takes the new byte, overrun is not set.

Timing and independence:
- TX and RX are independent and run full duplex.
- data_ready, tbre and tsre are registered outputs with no combinational paths from inputs.

Decomposition:
- Shared package uart_pkg holds:
  - tx/rx state enum typedefs;
  - UART_DATA_BITS=8;
  - the COM1 data/command address constants used by the controller.
- One sub-module, uart_rx_sampler: rxd synchroniser, mid-bit sampler and RX FSM. Outputs a byte plus a valid pulse and a framing_err pulse.
- The top level keeps the bus interface, THR/TSR, the TX FSM and the RBR/flag logic.

Test Plan (CLKS_PER_BIT=4):
- Reset then idle 20 cycles -> txd=1, tbre=1, tsre=1, data_ready=0, bus high-Z.
- Write 0xA5 (wrn low 1 cycle) -> tbre=0 for 1 cycle, then txd = 0, then 1,0,1,0,0,1,0,1, then 1, each 4 cycles; tsre=1 after stop.
- Write 0x11 then 0x22 while the first is shifting -> second accepted when tbre=1 again, contiguous frames with no idle bit; a third write while tbre==0 is ignored.
- Drive rxd frame 0x3C -> data_ready=1 one cycle after the stop mid-sample; rdn low gives bus_data=0x3C; the rdn rise clears data_ready.
- Two rx frames 0x01, 0x02 with no read -> overrun=1, RBR=0x02; a read clears overrun.
- Rx frame with stop=0 -> framing_err pulse, data_ready stays 0. Assert rst mid-TX -> txd=1 at once, tbre=tsre=1.
